// File: rtl/exmem_pipe_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush, optional skid entry
// and a saturating back-pressure counter.
//
// state | meaning
// EMPTY | main entry invalid
// ONE   | main valid, skid invalid
// TWO   | main and skid valid (SKID=1 only)
module exmem_pipe_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_op2,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  input  logic               in_mem_to_reg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_alu,
  output logic [DATA_W-1:0]  out_op2,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic               out_mem_to_reg,
  output logic [CNT_W-1:0]   stall_cnt,
  input  logic               stall_clr
);

  localparam int PW = 2*DATA_W + RADDR_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] in_beat, main_q, skid_q;
  logic          main_valid, skid_valid, accept, transfer;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == TWO);
  assign in_beat    = {in_alu, in_op2, in_rd, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg};
  // flush outranks both handshakes
  assign accept     = in_valid && in_ready && !flush;
  assign transfer   = main_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !transfer)      state_nxt = (SKID != 0) ? TWO : ONE;
          else if (!accept && transfer) state_nxt = EMPTY;
        end
        TWO:     if (transfer) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = main_valid;
    if (SKID != 0) in_ready = !skid_valid;
    else           in_ready = !main_valid || out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (skid_valid && transfer)                 main_q <= skid_q;
      else if (accept && (!main_valid || transfer)) main_q <= in_beat;
      if (accept && main_valid && !transfer)      skid_q <= in_beat;
    end
  end

  assign out_alu        = main_q[PW-1 -: DATA_W];
  assign out_op2        = main_q[PW-DATA_W-1 -: DATA_W];
  assign out_rd         = main_q[4 +: RADDR_W];
  assign out_reg_write  = main_q[3] & out_valid;
  assign out_mem_read   = main_q[2] & out_valid;
  assign out_mem_write  = main_q[1] & out_valid;
  assign out_mem_to_reg = main_q[0] & out_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Directed bench for exmem_pipe_stage: a SKID=1/CNT_W=4 instance and a SKID=0 instance
// share stimulus; a queue scoreboard tracks beats of the currently selected instance.
module tb_exmem_pipe_stage;

  localparam int PW = 73;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, stall_clr;
  logic [31:0] in_alu, in_op2;
  logic [4:0]  in_rd;
  logic        in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;

  logic        ir_1, ov_1, rw_1, mr_1, mw_1, mtr_1;
  logic [31:0] alu_1, op2_1;
  logic [4:0]  rd_1;
  logic [3:0]  st_1;
  logic        ir_0, ov_0, rw_0, mr_0, mw_0, mtr_0;
  logic [31:0] alu_0, op2_0;
  logic [4:0]  rd_0;
  logic [15:0] st_0;

  logic        sel;
  logic        ir, ov, orw, omr, omw, omtr;
  logic [31:0] oalu, oop2;
  logic [4:0]  ord;
  logic [15:0] ost;

  logic [PW-1:0] q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exmem_pipe_stage #(.DATA_W(32), .RADDR_W(5), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_1),
    .in_alu(in_alu), .in_op2(in_op2), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .out_valid(ov_1), .out_ready(out_ready), .out_alu(alu_1), .out_op2(op2_1), .out_rd(rd_1),
    .out_reg_write(rw_1), .out_mem_read(mr_1), .out_mem_write(mw_1), .out_mem_to_reg(mtr_1),
    .stall_cnt(st_1), .stall_clr(stall_clr));

  exmem_pipe_stage #(.DATA_W(32), .RADDR_W(5), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_0),
    .in_alu(in_alu), .in_op2(in_op2), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .out_valid(ov_0), .out_ready(out_ready), .out_alu(alu_0), .out_op2(op2_0), .out_rd(rd_0),
    .out_reg_write(rw_0), .out_mem_read(mr_0), .out_mem_write(mw_0), .out_mem_to_reg(mtr_0),
    .stall_cnt(st_0), .stall_clr(stall_clr));

  always_comb begin
    ir = sel ? ir_0 : ir_1;
    ov = sel ? ov_0 : ov_1;
    oalu = sel ? alu_0 : alu_1;
    oop2 = sel ? op2_0 : op2_1;
    ord = sel ? rd_0 : rd_1;
    orw = sel ? rw_0 : rw_1;
    omr = sel ? mr_0 : mr_1;
    omw = sel ? mw_0 : mw_1;
    omtr = sel ? mtr_0 : mtr_1;
    ost = sel ? st_0 : {12'd0, st_1};
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [3:0] ctl);
    in_valid = v; in_alu = a; in_op2 = b; in_rd = rd;
    {in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg} = ctl;
  endtask

  // Called just after a falling edge with inputs set; models the coming rising edge.
  task automatic cyc(input logic exp_ir);
    logic [PW-1:0] e;
    #1;
    chk("in_ready", ir, exp_ir);
    if (flush) begin
      q.delete();
    end else begin
      if (ov && out_ready) begin
        chk("sb_nonempty_at_transfer", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("beat", {oalu, oop2, ord, orw, omr, omw, omtr}, e);
        end
      end
      if (in_valid && exp_ir)
        q.push_back({in_alu, in_op2, in_rd, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg});
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  pat;
    logic [31:0] nb;
    logic        e_ir;
    sel = 1'b0; reset = 1'b1; flush = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
    drive(0, 0, 0, 0, 4'b0000);
    @(negedge clk); #1;
    chk("rst_out_valid", ov, 0);
    chk("rst_in_ready", ir, 1);
    chk("rst_out_alu", oalu, 0);
    chk("rst_out_rd", ord, 0);
    chk("rst_ctl", {orw, omr, omw, omtr}, 0);
    chk("rst_stall", ost, 0);
    reset = 1'b0;
    @(negedge clk);

    // stream with no back-pressure
    out_ready = 1'b1;
    drive(1, 32'h10, 32'h100, 5'd1, 4'b1000); cyc(1);
    drive(1, 32'h11, 32'h101, 5'd2, 4'b1001); cyc(1);
    drive(1, 32'h12, 32'h102, 5'd3, 4'b0100); cyc(1);
    drive(0, 0, 0, 0, 4'b0000); cyc(1);
    cyc(1);
    chk("t1_drained_valid", ov, 0);
    chk("t1_stall", ost, 0);
    chk("t1_sb_empty", q.size(), 0);

    // back-pressure into skid
    out_ready = 1'b0;
    drive(1, 32'hAAAA0001, 32'h1, 5'd7, 4'b1000); cyc(1);
    drive(1, 32'hBBBB0002, 32'h2, 5'd8, 4'b0010); cyc(1);
    drive(0, 0, 0, 0, 4'b0000); cyc(0);
    cyc(0);
    chk("t2_hold_alu", oalu, 32'hAAAA0001);
    chk("t2_stall", ost, 3);
    out_ready = 1'b1;
    cyc(0);
    cyc(1);
    cyc(1);
    chk("t2_sb_empty", q.size(), 0);
    chk("t2_stall_after", ost, 3);

    // flush kills held store and incoming beat
    out_ready = 1'b0;
    drive(1, 32'h5, 32'h55, 5'd9, 4'b0010); cyc(1);
    flush = 1'b1;
    drive(1, 32'hDEAD, 32'h66, 5'd10, 4'b1000); cyc(1);
    flush = 1'b0;
    drive(0, 0, 0, 0, 4'b0000);
    #1;
    chk("t3_valid", ov, 0);
    chk("t3_mem_write", omw, 0);
    chk("t3_stall_kept", ost, 4);
    out_ready = 1'b1;
    cyc(1);
    cyc(1);
    chk("t3_no_ghost", ov, 0);

    // bubble gating of controls
    drive(1, 32'h20, 32'h0, 5'd4, 4'b1000); cyc(1);
    drive(0, 32'h21, 32'h0, 5'd5, 4'b1110); cyc(1);
    #1;
    chk("t4_valid", ov, 0);
    chk("t4_reg_write", orw, 0);
    chk("t4_mem_read", omr, 0);

    // counter saturation and clear priority
    drive(0, 0, 0, 0, 4'b0000);
    stall_clr = 1'b1; cyc(1);
    stall_clr = 1'b0;
    chk("t5_clr_idle", ost, 0);
    out_ready = 1'b0;
    drive(1, 32'h30, 32'h3, 5'd6, 4'b0101); cyc(1);
    drive(0, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 20; i++) cyc(1);
    chk("t5_saturated", ost, 15);
    stall_clr = 1'b1; cyc(1);
    stall_clr = 1'b0;
    chk("t5_clr_over_inc", ost, 0);
    cyc(1);
    chk("t5_inc_after_clr", ost, 1);
    out_ready = 1'b1; cyc(1);
    chk("t5_sb_empty", q.size(), 0);

    // async reset while in TWO
    out_ready = 1'b0;
    drive(1, 32'hC0, 32'hC, 5'd11, 4'b1000); cyc(1);
    drive(1, 32'hD0, 32'hD, 5'd12, 4'b0010); cyc(1);
    drive(0, 0, 0, 0, 4'b0000);
    #1;
    chk("t7_full", ir, 0);
    #1 reset = 1'b1;
    #1;
    chk("t7_async_valid", ov, 0);
    chk("t7_async_ready", ir, 1);
    chk("t7_async_alu", oalu, 0);
    chk("t7_async_stall", ost, 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    cyc(1);
    cyc(1);
    chk("t7_no_stale", ov, 0);

    // SKID=0 instance: combinational in_ready
    sel = 1'b1;
    reset = 1'b1; out_ready = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_rst_ready", ir, 1);
    pat = 8'b1011_0101;
    nb = 32'h40;
    for (int i = 0; i < 8; i++) begin
      out_ready = pat[i];
      drive(1, nb, ~nb, nb[4:0], nb[3:0]);
      e_ir = (q.size() == 0) || out_ready;
      cyc(e_ir);
      if (e_ir) nb = nb + 32'd1;
    end
    drive(0, 0, 0, 0, 4'b0000);
    out_ready = 1'b1;
    cyc(1);
    cyc(1);
    chk("t6_sb_empty", q.size(), 0);
    chk("t6_drained", ov, 0);
    chk("t6_beats_sent", nb, 32'h45);
    chk("t6_stall", ost, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
